// File: rtl/erv_pkg.sv
// erv_pkg: definitions shared by the memory stage and its helpers.
//   - FLAG_LOAD / FLAG_STORE: bit positions inside the 17-bit control flags
//   - F3_*: funct3 access size/sign encodings
//   - mem_state_e: memory stage FSM states
//   - helpers mapping funct3/address to lane offset, byte enables and
//     replicated store data
package erv_pkg;

    localparam int FLAG_W     = 17;
    localparam int FLAG_LOAD  = 0;
    localparam int FLAG_STORE = 1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Unused encodings (011/110/111) fall through to a full word access.
    function automatic mem_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_BYTE;
            F3_H, F3_HU: size_of = SZ_HALF;
            default:     size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_e sz, input logic [1:0] a);
        case (sz)
            SZ_HALF: misaligned = a[0];
            SZ_WORD: misaligned = (a != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    // Lane offset with low bits dropped to the access's natural alignment.
    function automatic logic [1:0] natural_off(input mem_size_e sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: natural_off = a;
            SZ_HALF: natural_off = {a[1], 1'b0};
            default: natural_off = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input mem_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: be_of = 4'b0001 << off;
            SZ_HALF: be_of = 4'b0011 << off;
            default: be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input mem_size_e sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: wdata_of = {4{d[7:0]}};
            SZ_HALF: wdata_of = {2{d[15:0]}};
            default: wdata_of = d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational lane selection and extension of load data.
//   rdata  in  32  raw bus word
//   offset in  2   byte lane offset (already naturally aligned)
//   funct3 in  3   access size/sign (bit 2 set = zero-extend)
//   data   out 32  aligned, extended load result
module load_align
    import erv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        half_v = 16'h0000;
        data   = rdata;
        case (offset)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size_of(funct3))
            SZ_BYTE: data = {{24{byte_v[7] & ~funct3[2]}}, byte_v};
            SZ_HALF: data = {{16{half_v[15] & ~funct3[2]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a single-outstanding data bus port.
//   clk, rst                 clock / async active-high reset
//   result_in, rd_in,        op from execute: ALU result or effective
//   flags_in, funct3_in,     address, destination, control flags,
//   store_data_in            access size/sign, store data
//   dbus_*                   registered data bus request, ack/rdata in
//   wb_data, wb_rd, wb_flags registered writeback (rd/flags 0 = bubble)
//   stall                    combinational hold request to upstream
//   misalign_trap, trap_addr misaligned access report
// Build option: MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses
// into a one-cycle trap instead of forcing natural alignment.
//
// Handshake: an op is presented while IDLE; if it is a memory op the stage
// raises stall and upstream keeps its inputs unchanged. The bus request is
// held stable from BUSY entry until the cycle dbus_ack=1; that cycle stall
// drops and the writeback appears at the following edge.
// The internal signal `state` is the FSM state for checkers.
module mem_stage
    import erv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       result_in,
    input  logic [4:0]        rd_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [2:0]        funct3_in,
    input  logic [31:0]       store_data_in,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [31:0]       dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic [FLAG_W-1:0] wb_flags,
    output logic              stall,
    output logic              misalign_trap,
    output logic [31:0]       trap_addr
);

    mem_state_e state, state_nx;

    logic      is_load_in, is_store_in, mem_op, trap_now;
    mem_size_e size_in;
    logic [1:0] off_in;

    // Op captured at BUSY entry.
    logic [4:0]        h_rd;
    logic [FLAG_W-1:0] h_flags;
    logic [31:0]       h_result;
    logic [2:0]        h_funct3;
    logic [1:0]        h_off;
    logic              h_load;
    logic [31:0]       load_data;

    assign is_load_in  = flags_in[FLAG_LOAD];
    assign is_store_in = flags_in[FLAG_STORE];
    assign mem_op      = is_load_in | is_store_in;
    assign size_in     = size_of(funct3_in);
    assign off_in      = natural_off(size_in, result_in[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_now = mem_op && misaligned(size_in, result_in[1:0]);
`else
    assign trap_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MEM_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (mem_op && !trap_now) begin
                    state_nx = MEM_BUSY;
                    stall    = 1'b1;
                end
            end
            MEM_BUSY: begin
                if (dbus_ack) state_nx = MEM_IDLE;
                else          stall    = 1'b1;
            end
            default: state_nx = MEM_IDLE;
        endcase
        // Every output reads 0 while reset is asserted, stall included.
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
            wb_data    <= '0;
            wb_rd      <= '0;
            wb_flags   <= '0;
            h_rd       <= '0;
            h_flags    <= '0;
            h_result   <= '0;
            h_funct3   <= '0;
            h_off      <= '0;
            h_load     <= 1'b0;
        end else begin
            // Bubble unless an op completes this cycle.
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_flags <= '0;
            case (state)
                MEM_IDLE: begin
                    if (!mem_op) begin
                        wb_data  <= result_in;
                        wb_rd    <= rd_in;
                        wb_flags <= flags_in;
                    end else if (!trap_now) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store_in;
                        dbus_addr  <= {result_in[31:2], 2'b00};
                        dbus_be    <= be_of(size_in, off_in);
                        dbus_wdata <= wdata_of(size_in, store_data_in);
                        h_rd       <= rd_in;
                        h_flags    <= flags_in;
                        h_result   <= result_in;
                        h_funct3   <= funct3_in;
                        h_off      <= off_in;
                        h_load     <= is_load_in;
                    end
                end
                MEM_BUSY: begin
                    if (dbus_ack) begin
                        dbus_req   <= 1'b0;
                        dbus_we    <= 1'b0;
                        dbus_addr  <= '0;
                        dbus_be    <= '0;
                        dbus_wdata <= '0;
                        wb_data    <= h_load ? load_data : h_result;
                        wb_rd      <= h_rd;
                        wb_flags   <= h_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    load_align u_load_align (
        .rdata  (dbus_rdata),
        .offset (h_off),
        .funct3 (h_funct3),
        .data   (load_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic        trap_q;
    logic [31:0] trap_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            trap_q      <= (state == MEM_IDLE) && trap_now;
            trap_addr_q <= ((state == MEM_IDLE) && trap_now) ? result_in : 32'h0;
        end
    end

    assign misalign_trap = trap_q;
    assign trap_addr     = trap_addr_q;
`else
    assign misalign_trap = 1'b0;
    assign trap_addr     = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table plus randomized checks of mem_stage against
// a byte-lane arithmetic model of the access rules.
module tb_mem_stage;
  import erv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_in;
  logic [4:0]  rd_in;
  logic [16:0] flags_in;
  logic [2:0]  funct3_in;
  logic [31:0] store_data_in;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [16:0] wb_flags;
  logic        stall, misalign_trap;
  logic [31:0] trap_addr;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .result_in(result_in), .rd_in(rd_in), .flags_in(flags_in),
    .funct3_in(funct3_in), .store_data_in(store_data_in),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_flags(wb_flags),
    .stall(stall), .misalign_trap(misalign_trap), .trap_addr(trap_addr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  // Lane offset rounded down to a multiple of the access size.
  function automatic int m_off(input int n, input logic [31:0] addr);
    int a;
    a = int'(addr[1:0]);
    return (a / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input int n, input int off);
    int v;
    v = ((1 << n) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = d[(i % n)*8 +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    int n;
    longint v;
    logic [63:0] r;
    n = m_size(f3);
    v = longint'(rdata >> (off * 8)) & ((longint'(1) << (8 * n)) - 1);
    if (n < 4 && !f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    r = 64'(v);
    return r[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble;
    result_in = '0; rd_in = '0; flags_in = '0; funct3_in = '0; store_data_in = '0;
  endtask

  task automatic mem_txn(input string tag, input logic [16:0] flags, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int dly, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    logic st;
    st = flags[FLAG_STORE];
    exp_q.push_back(exp_wb);
    result_in = addr; rd_in = rd; flags_in = flags; funct3_in = f3; store_data_in = sdata;
    #1 check({tag, ".stall_issue"}, 32'(stall), 32'd1);
    tick;
    check({tag, ".req"}, 32'(dbus_req), 32'd1);
    check({tag, ".we"}, 32'(dbus_we), 32'(st));
    check({tag, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
    check({tag, ".be"}, 32'(dbus_be), 32'(exp_be));
    if (st) check({tag, ".wdata"}, dbus_wdata, exp_wdata);
    for (int k = 0; k < dly; k++) begin
      check({tag, ".stall_wait"}, 32'(stall), 32'd1);
      tick;
      check({tag, ".addr_hold"}, dbus_addr, {addr[31:2], 2'b00});
      check({tag, ".req_hold"}, 32'(dbus_req), 32'd1);
      check({tag, ".wb_rd_bubble"}, 32'(wb_rd), 32'd0);
    end
    dbus_ack = 1'b1; dbus_rdata = rdata;
    #1 check({tag, ".stall_ack"}, 32'(stall), 32'd0);
    tick;
    dbus_ack = 1'b0; dbus_rdata = $urandom;
    drive_bubble;
    check({tag, ".wb_data"}, wb_data, exp_q.pop_front());
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    check({tag, ".wb_flags"}, 32'(wb_flags), 32'(flags));
    check({tag, ".req_drop"}, 32'(dbus_req), 32'd0);
  endtask

  task automatic nonmem(input string tag, input logic [31:0] res, input logic [4:0] rd,
                        input logic [16:0] flags);
    result_in = res; rd_in = rd; flags_in = flags; funct3_in = 3'($urandom_range(0, 7));
    store_data_in = $urandom;
    #1 check({tag, ".stall"}, 32'(stall), 32'd0);
    tick;
    drive_bubble;
    check({tag, ".wb_data"}, wb_data, res);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    check({tag, ".wb_flags"}, 32'(wb_flags), 32'(flags));
    check({tag, ".req"}, 32'(dbus_req), 32'd0);
    tick;
    check({tag, ".bubble_rd"}, 32'(wb_rd), 32'd0);
    check({tag, ".bubble_flags"}, 32'(wb_flags), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [16:0] flags;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  localparam logic [16:0] LD = 17'h00001;
  localparam logic [16:0] SD = 17'h00002;

  vec_t vecs[9];

  initial begin
    logic [16:0] fl;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rdv, exp_wb;
    int n, off, dly;
    logic is_st;

    vecs[0] = '{LD | 17'h10000, F3_B,  32'h0000_1003, 32'h0, 32'h80FF_FF11, 0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    vecs[1] = '{SD | 17'h00100, F3_H,  32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2002};
    vecs[2] = '{LD,              F3_W,  32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 3, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    vecs[3] = '{LD,              F3_BU, 32'h0000_1001, 32'h0, 32'h1234_5678, 1, 4'b0010, 32'h0, 32'h0000_0056};
    vecs[4] = '{LD,              F3_H,  32'h0000_1002, 32'h0, 32'h8001_0000, 0, 4'b1100, 32'h0, 32'hFFFF_8001};
    vecs[5] = '{LD,              F3_HU, 32'h0000_1000, 32'h0, 32'h0000_F00D, 2, 4'b0011, 32'h0, 32'h0000_F00D};
    vecs[6] = '{SD,              F3_B,  32'h0000_0005, 32'h1234_56A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0005};
    vecs[7] = '{SD,              F3_W,  32'h0000_0008, 32'hCAFE_BABE, 32'h0, 1, 4'b1111, 32'hCAFE_BABE, 32'h0000_0008};
    vecs[8] = '{LD,              3'b011, 32'h0000_0010, 32'h0, 32'h0102_0304, 0, 4'b1111, 32'h0, 32'h0102_0304};

    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = '0;
    drive_bubble;
    tick; tick;
    check("reset.req", 32'(dbus_req), 32'd0);
    check("reset.wb_rd", 32'(wb_rd), 32'd0);
    check("reset.wb_data", wb_data, 32'd0);
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.trap", 32'(misalign_trap), 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 9; i++)
      mem_txn($sformatf("vec%0d", i), vecs[i].flags, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
              5'(i + 1), vecs[i].rdata, vecs[i].dly, vecs[i].be, vecs[i].wdata, vecs[i].wb);

    // Non-memory op passes straight through.
    nonmem("alu", 32'h0000_1234, 5'd5, 17'h00004);

    // Ack while idle has no effect.
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    #1 check("idle_ack.stall", 32'(stall), 32'd0);
    tick;
    dbus_ack = 1'b0;
    check("idle_ack.req", 32'(dbus_req), 32'd0);
    check("idle_ack.wb_rd", 32'(wb_rd), 32'd0);

    // Misaligned word access.
`ifdef MEM_MISALIGN_TRAP_EN
    result_in = 32'h0000_3001; rd_in = 5'd7; flags_in = LD; funct3_in = F3_W;
    #1 check("misalign.stall", 32'(stall), 32'd0);
    tick;
    drive_bubble;
    check("misalign.trap", 32'(misalign_trap), 32'd1);
    check("misalign.trap_addr", trap_addr, 32'h0000_3001);
    check("misalign.req", 32'(dbus_req), 32'd0);
    check("misalign.wb_rd", 32'(wb_rd), 32'd0);
    check("misalign.wb_flags", 32'(wb_flags), 32'd0);
    tick;
    check("misalign.trap_pulse", 32'(misalign_trap), 32'd0);
`else
    mem_txn("misalign", LD, F3_W, 32'h0000_3001, 32'h0, 5'd7, 32'h7777_1234, 0, 4'b1111,
            32'h0, 32'h7777_1234);
    check("misalign.trap", 32'(misalign_trap), 32'd0);
    check("misalign.trap_addr", trap_addr, 32'd0);
`endif

    // Reset in the middle of an access aborts it.
    result_in = 32'h0000_5000; rd_in = 5'd9; flags_in = LD; funct3_in = F3_W;
    tick;
    check("rst_busy.req_before", 32'(dbus_req), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_busy.req_async", 32'(dbus_req), 32'd0);
    check("rst_busy.stall", 32'(stall), 32'd0);
    drive_bubble;
    tick;
    rst = 1'b0;
    dbus_ack = 1'b1; dbus_rdata = 32'h5555_AAAA;
    #1 check("rst_busy.late_ack_stall", 32'(stall), 32'd0);
    tick;
    dbus_ack = 1'b0;
    check("rst_busy.wb_rd", 32'(wb_rd), 32'd0);
    check("rst_busy.wb_flags", 32'(wb_flags), 32'd0);
    check("rst_busy.req", 32'(dbus_req), 32'd0);

    // Randomized ops against the model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        fl = 17'($urandom) & ~(LD | SD);
        nonmem($sformatf("rnd%0d", it), $urandom, 5'($urandom), fl);
      end else begin
        is_st = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        if (is_st && (f3 == 3'b100 || f3 == 3'b101)) f3 = f3 & 3'b011;
        n = m_size(f3);
        addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
        addr = addr & ~32'(n - 1);
`endif
        off = m_off(n, addr);
        fl = (17'($urandom) & ~(LD | SD)) | (is_st ? SD : LD);
        sd = $urandom; rdv = $urandom; dly = $urandom_range(0, 3);
        exp_wb = is_st ? addr : m_load(f3, off, rdv);
        mem_txn($sformatf("rnd%0d", it), fl, f3, addr, sd, 5'($urandom), rdv, dly,
                m_be(n, off), m_wdata(n, sd), exp_wb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
